// File: rtl/old_control_decoder_if.sv
// Opcode-in / control-word-out bundle for the main control decoder.
// master: the fetch side that supplies the opcode and consumes control strobes.
// slave:  the decoder itself.
interface old_control_decoder_if;
  logic [5:0] opcode;
  logic       ALUsrc;
  logic [1:0] ALUop;
  logic       RegDst;
  logic       MemWrite;
  logic       MemRead;
  logic       Beq;
  logic       Bne;
  logic       Jump;
  logic       MemToReg;
  logic       RegWrite;
  logic       illegal;

  modport master (
    output opcode,
    input  ALUsrc, ALUop, RegDst, MemWrite, MemRead, Beq, Bne, Jump, MemToReg, RegWrite,
    input  illegal
  );

  modport slave (
    input  opcode,
    output ALUsrc, ALUop, RegDst, MemWrite, MemRead, Beq, Bne, Jump, MemToReg, RegWrite,
    output illegal
  );
endinterface

// File: rtl/old_control_decoder.sv
// Main control decoder for the single-cycle MIPS-subset datapath.
// Decodes opcode[31:26] into control strobes, registered one cycle so the
// control word lines up with the following latch stage. Unknown opcodes give
// an all-zero control word with the illegal flag raised.
module old_control_decoder (
  input  logic                        clk,
  input  logic                        rst_n,
  old_control_decoder_if.slave        bus
);

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  logic       w_alu_src;
  logic [1:0] w_alu_op;
  logic       w_reg_dst;
  logic       w_mem_write;
  logic       w_mem_read;
  logic       w_beq;
  logic       w_bne;
  logic       w_jump;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_illegal;

  logic       r_alu_src;
  logic [1:0] r_alu_op;
  logic       r_reg_dst;
  logic       r_mem_write;
  logic       r_mem_read;
  logic       r_beq;
  logic       r_bne;
  logic       r_jump;
  logic       r_mem_to_reg;
  logic       r_reg_write;
  logic       r_illegal;

  // Combinational opcode decode; exact-match case so X/Z opcodes fall to default.
  always_comb begin
    w_alu_src    = 1'b0;
    w_alu_op     = AluAdd;
    w_reg_dst    = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_beq        = 1'b0;
    w_bne        = 1'b0;
    w_jump       = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    case (bus.opcode)
      OpRType: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        w_alu_op    = AluFunct;
      end
      OpLw: begin
        w_alu_src    = 1'b1;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_mem_read   = 1'b1;
      end
      OpSw: begin
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      OpBeq: begin
        w_beq    = 1'b1;
        w_alu_op = AluSub;
      end
      OpBne: begin
        w_bne    = 1'b1;
        w_alu_op = AluSub;
      end
      OpJ: begin
        w_jump = 1'b1;
      end
      OpAddi: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // Control word register; cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_src    <= 1'b0;
      r_alu_op     <= 2'b00;
      r_reg_dst    <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_beq        <= 1'b0;
      r_bne        <= 1'b0;
      r_jump       <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_alu_src    <= w_alu_src;
      r_alu_op     <= w_alu_op;
      r_reg_dst    <= w_reg_dst;
      r_mem_write  <= w_mem_write;
      r_mem_read   <= w_mem_read;
      r_beq        <= w_beq;
      r_bne        <= w_bne;
      r_jump       <= w_jump;
      r_mem_to_reg <= w_mem_to_reg;
      r_reg_write  <= w_reg_write;
      r_illegal    <= w_illegal;
    end
  end

  assign bus.ALUsrc   = r_alu_src;
  assign bus.ALUop    = r_alu_op;
  assign bus.RegDst   = r_reg_dst;
  assign bus.MemWrite = r_mem_write;
  assign bus.MemRead  = r_mem_read;
  assign bus.Beq      = r_beq;
  assign bus.Bne      = r_bne;
  assign bus.Jump     = r_jump;
  assign bus.MemToReg = r_mem_to_reg;
  assign bus.RegWrite = r_reg_write;
  assign bus.illegal  = r_illegal;

endmodule

// File: tb/tb_old_control_decoder.sv
// Self-checking bench for old_control_decoder: directed cases then randomized
// opcodes against a table-driven reference model.
module tb_old_control_decoder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  old_control_decoder_if bus ();

  old_control_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference table; word order is
  // {RegDst, ALUsrc, MemToReg, RegWrite, MemRead, MemWrite, Beq, Bne, Jump, ALUop, illegal}
  typedef struct {
    logic [5:0]  op;
    logic [11:0] word;
  } ref_entry_t;

  ref_entry_t ref_tbl [7];

  initial begin
    ref_tbl[0] = '{op: 6'b000000, word: 12'b1_0_0_1_0_0_0_0_0_10_0};
    ref_tbl[1] = '{op: 6'b100011, word: 12'b0_1_1_1_1_0_0_0_0_00_0};
    ref_tbl[2] = '{op: 6'b101011, word: 12'b0_1_0_0_0_1_0_0_0_00_0};
    ref_tbl[3] = '{op: 6'b000100, word: 12'b0_0_0_0_0_0_1_0_0_01_0};
    ref_tbl[4] = '{op: 6'b000101, word: 12'b0_0_0_0_0_0_0_1_0_01_0};
    ref_tbl[5] = '{op: 6'b000010, word: 12'b0_0_0_0_0_0_0_0_1_00_0};
    ref_tbl[6] = '{op: 6'b001000, word: 12'b0_1_0_1_0_0_0_0_0_00_0};
  end

  function automatic logic [11:0] ref_word(input logic [5:0] op);
    for (int k = 0; k < 7; k++) begin
      if (ref_tbl[k].op == op) return ref_tbl[k].word;
    end
    return 12'b0000_0000_0001;
  endfunction

  function automatic logic [11:0] obs_word();
    return {bus.RegDst, bus.ALUsrc, bus.MemToReg, bus.RegWrite, bus.MemRead, bus.MemWrite,
            bus.Beq, bus.Bne, bus.Jump, bus.ALUop, bus.illegal};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Structural invariants of any legal control word.
  task automatic check_invariants(input string tag);
    logic [11:0] w;
    w = obs_word();
    check({tag, "_br1hot"}, 12'(($countones({w[5], w[4], w[3]}) <= 1)), 12'd1);
    check({tag, "_memrw"}, 12'(!(w[7] && w[6])), 12'd1);
    check({tag, "_m2r"}, 12'(!(w[9] && !w[7])), 12'd1);
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [5:0] op, input string tag);
    bus.opcode = op;
    tick();
    check(tag, obs_word(), ref_word(op));
  endtask

  logic [5:0] legal_ops [7];

  initial begin
    n_checks = 0;
    n_errors = 0;
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b001000};

    // 1: reset holds outputs low even across clock edges
    rst_n      = 1'b0;
    bus.opcode = 6'b000000;
    #3;
    check("reset_async", obs_word(), 12'd0);
    tick();
    check("reset_held", obs_word(), 12'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rtype_after_rst", obs_word(), 12'b1_0_0_1_0_0_0_0_0_10_0);

    // 2: lw then sw with 1-cycle lag
    bus.opcode = 6'b100011;
    #2;
    check("lag_before_edge", obs_word(), 12'b1_0_0_1_0_0_0_0_0_10_0);
    tick();
    check("lw", obs_word(), 12'b0_1_1_1_1_0_0_0_0_00_0);
    bus.opcode = 6'b101011;
    #2;
    check("lw_held", obs_word(), 12'b0_1_1_1_1_0_0_0_0_00_0);
    tick();
    check("sw", obs_word(), 12'b0_1_0_0_0_1_0_0_0_00_0);

    // 3-5: branches, jump, addi, illegal
    apply(6'b000100, "beq");
    apply(6'b000101, "bne");
    apply(6'b000010, "jump");
    apply(6'b001000, "addi");
    apply(6'b111011, "illegal_3b");
    check("illegal_3b_const", obs_word(), 12'b0000_0000_0001);
    apply(6'b100001, "illegal_21");
    check("illegal_21_const", obs_word(), 12'b0000_0000_0001);

    // 6: asynchronous reset pulse between edges
    apply(6'b100011, "lw_pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", obs_word(), 12'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check("still_clear", obs_word(), 12'd0);
    tick();
    check("lw_restored", obs_word(), 12'b0_1_1_1_1_0_0_0_0_00_0);

    // Randomized mix of legal and arbitrary opcodes
    for (int i = 0; i < 300; i++) begin
      logic [5:0] op;
      if ($urandom_range(0, 1) == 1) op = legal_ops[$urandom_range(0, 6)];
      else op = 6'($urandom);
      apply(op, "rand");
      check_invariants("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
